// File: rtl/dualmem_pkg.sv
// Shared helpers for the asymmetric dual-port RAM: address/lane widths,
// narrow-to-wide byte-enable expansion and the read-latency legality check.
package dualmem_pkg;

    localparam int MAX_BE  = 256;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Moves a narrow-port byte-enable group into the byte positions of lane `lane`.
    function automatic logic [MAX_BE-1:0] expand_be(
        input logic [MAX_BE-1:0] be,
        input int                nb,
        input int                lane
    );
        return be << (nb * lane);
    endfunction

    function automatic bit read_lat_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/dualmem_lane.sv
// One DEPTH x W true dual-port byte-enable RAM lane, read-first, registered reads.
// DUALMEM_WRITE_FORWARD_EN turns cross-port same-address reads into write-first.
module dualmem_lane
    import dualmem_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     a_en_i,
    input  logic [W/8-1:0]           a_be_i,
    input  logic [$clog2(DEPTH)-1:0] a_addr_i,
    input  logic [W-1:0]             a_wdata_i,
    output logic [W-1:0]             a_rdata_o,
    input  logic                     b_en_i,
    input  logic [W/8-1:0]           b_be_i,
    input  logic [$clog2(DEPTH)-1:0] b_addr_i,
    input  logic [W-1:0]             b_wdata_i,
    output logic [W-1:0]             b_rdata_o
);

    localparam int NB = W / 8;

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_a_rdata;
    logic [W-1:0] r_b_rdata;
    logic [W-1:0] w_a_rd_data;
    logic [W-1:0] w_b_rd_data;
    logic         w_a_rd;
    logic         w_b_rd;

    assign w_a_rd = a_en_i & ~(|a_be_i);
    assign w_b_rd = b_en_i & ~(|b_be_i);

    // Port B is applied last so it wins a same-byte write/write collision.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (a_en_i && a_be_i[i]) begin
                r_mem[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (b_en_i && b_be_i[i]) begin
                r_mem[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_a_rd_data = r_mem[a_addr_i];
        w_b_rd_data = r_mem[b_addr_i];
`ifdef DUALMEM_WRITE_FORWARD_EN
        for (int i = 0; i < NB; i++) begin
            if (b_en_i && b_be_i[i] && (b_addr_i == a_addr_i)) begin
                w_a_rd_data[i*8 +: 8] = b_wdata_i[i*8 +: 8];
            end
            if (a_en_i && a_be_i[i] && (a_addr_i == b_addr_i)) begin
                w_b_rd_data[i*8 +: 8] = a_wdata_i[i*8 +: 8];
            end
        end
`endif
    end

    // Read registers only load on a read, so data holds between requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (w_a_rd) r_a_rdata <= w_a_rd_data;
            if (w_b_rd) r_b_rdata <= w_b_rd_data;
        end
    end

    assign a_rdata_o = r_a_rdata;
    assign b_rdata_o = r_b_rdata;

endmodule

// File: rtl/dualmem_widen_param.sv
// Asymmetric true dual-port RAM: narrow port A, wide port B (RATIO lanes),
// byte enables, 1/2-cycle read latency, sticky collision flag.
// Optional write-first bypass: DUALMEM_WRITE_FORWARD_EN (handled in the lanes).
module dualmem_widen_param
    import dualmem_pkg::*;
#(
    parameter int NARROW_W   = 16,
    parameter int RATIO      = 4,
    parameter int WIDE_DEPTH = 512,
    parameter int READ_LAT   = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                a_en_i,
    input  logic [NARROW_W/8-1:0]               a_be_i,
    input  logic [$clog2(WIDE_DEPTH*RATIO)-1:0] a_addr_i,
    input  logic [NARROW_W-1:0]                 a_wdata_i,
    output logic [NARROW_W-1:0]                 a_rdata_o,
    output logic                                a_rvalid_o,
    input  logic                                b_en_i,
    input  logic [NARROW_W*RATIO/8-1:0]         b_be_i,
    input  logic [$clog2(WIDE_DEPTH)-1:0]       b_addr_i,
    input  logic [NARROW_W*RATIO-1:0]           b_wdata_i,
    output logic [NARROW_W*RATIO-1:0]           b_rdata_o,
    output logic                                b_rvalid_o,
    output logic                                coll_o,
    input  logic                                coll_clr_i
);

    localparam int  NB     = NARROW_W / 8;
    localparam int  WB     = NB * RATIO;
    localparam int  WIDE_W = NARROW_W * RATIO;
    localparam int  B_AW   = addr_w(WIDE_DEPTH);
    localparam int  LANE_W = lane_w(RATIO);
    localparam int  LOG2R  = (RATIO > 1) ? $clog2(RATIO) : 0;
    localparam bit  LAT_OK = read_lat_ok(READ_LAT);

    generate
        if (!LAT_OK) begin : g_bad_lat
            $fatal(1, "dualmem_widen_param: READ_LAT must be 1 or 2");
        end
    endgenerate

    logic [B_AW-1:0]     w_a_word;
    logic [LANE_W-1:0]   w_a_lane;
    logic                w_a_rd;
    logic                w_a_wr;
    logic                w_b_rd;
    logic                w_b_wr;
    logic [WB-1:0]       w_a_be_wide;
    logic                w_coll;
    logic [NARROW_W-1:0] w_lane_a_rdata [RATIO];
    logic [WIDE_W-1:0]   w_b_cat;
    logic [NARROW_W-1:0] w_a_mux;

    logic                r_a_vld;
    logic                r_b_vld;
    logic [LANE_W-1:0]   r_a_sel;
    logic                r_coll;

    generate
        if (RATIO > 1) begin : g_lane_idx
            assign w_a_lane = a_addr_i[LANE_W-1:0];
            assign w_a_word = a_addr_i[LOG2R +: B_AW];
        end else begin : g_no_lane_idx
            assign w_a_lane = '0;
            assign w_a_word = a_addr_i;
        end
    endgenerate

    assign w_a_rd = a_en_i & ~(|a_be_i);
    assign w_a_wr = a_en_i &  (|a_be_i);
    assign w_b_rd = b_en_i & ~(|b_be_i);
    assign w_b_wr = b_en_i &  (|b_be_i);

    assign w_a_be_wide = WB'(expand_be(MAX_BE'(a_be_i), NB, int'(w_a_lane)));
    assign w_coll      = w_a_wr & w_b_wr & (w_a_word == b_addr_i) & (|(w_a_be_wide & b_be_i));

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            logic w_a_lane_en;
            logic w_b_lane_en;

            // A lane joins a port B write only if it has bytes enabled, so
            // untouched lanes keep their read registers steady.
            assign w_a_lane_en = a_en_i & (w_a_lane == LANE_W'(gi));
            assign w_b_lane_en = b_en_i & (w_b_rd | (|b_be_i[gi*NB +: NB]));

            dualmem_lane #(
                .W     (NARROW_W),
                .DEPTH (WIDE_DEPTH)
            ) u_lane (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .a_en_i    (w_a_lane_en),
                .a_be_i    (a_be_i),
                .a_addr_i  (w_a_word),
                .a_wdata_i (a_wdata_i),
                .a_rdata_o (w_lane_a_rdata[gi]),
                .b_en_i    (w_b_lane_en),
                .b_be_i    (b_be_i[gi*NB +: NB]),
                .b_addr_i  (b_addr_i),
                .b_wdata_i (b_wdata_i[gi*NARROW_W +: NARROW_W]),
                .b_rdata_o (w_b_cat[gi*NARROW_W +: NARROW_W])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_vld <= 1'b0;
            r_b_vld <= 1'b0;
            r_a_sel <= '0;
        end else begin
            r_a_vld <= w_a_rd;
            r_b_vld <= w_b_rd;
            if (w_a_rd) r_a_sel <= w_a_lane;
        end
    end

    assign w_a_mux = w_lane_a_rdata[r_a_sel];

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic                r_a_vld2;
            logic                r_b_vld2;
            logic [NARROW_W-1:0] r_a_rdata2;
            logic [WIDE_W-1:0]   r_b_rdata2;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_a_vld2   <= 1'b0;
                    r_b_vld2   <= 1'b0;
                    r_a_rdata2 <= '0;
                    r_b_rdata2 <= '0;
                end else begin
                    r_a_vld2 <= r_a_vld;
                    r_b_vld2 <= r_b_vld;
                    if (r_a_vld) r_a_rdata2 <= w_a_mux;
                    if (r_b_vld) r_b_rdata2 <= w_b_cat;
                end
            end

            assign a_rdata_o  = r_a_rdata2;
            assign a_rvalid_o = r_a_vld2;
            assign b_rdata_o  = r_b_rdata2;
            assign b_rvalid_o = r_b_vld2;
        end else begin : g_lat1
            assign a_rdata_o  = w_a_mux;
            assign a_rvalid_o = r_a_vld;
            assign b_rdata_o  = w_b_cat;
            assign b_rvalid_o = r_b_vld;
        end
    endgenerate

    // A new collision outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_coll <= 1'b0;
        end else if (w_coll) begin
            r_coll <= 1'b1;
        end else if (coll_clr_i) begin
            r_coll <= 1'b0;
        end
    end

    assign coll_o = r_coll;

endmodule

// File: tb/tb_dualmem_widen_param.sv
// Bench for dualmem_widen_param: directed vector table plus random traffic,
// both checked against a flat byte-array memory model; LAT=1 and LAT=2 instances.
module tb_dualmem_widen_param;

    localparam int NB  = 2;
    localparam int WB  = 8;
    localparam int D   = 512;
`ifdef DUALMEM_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_en, b_en, clr;
    logic [1:0]  a_be;
    logic [10:0] a_addr;
    logic [15:0] a_wd;
    logic [7:0]  b_be;
    logic [8:0]  b_addr;
    logic [63:0] b_wd;

    logic [15:0] a_rd1, a_rd2;
    logic [63:0] b_rd1, b_rd2;
    logic        a_v1, a_v2, b_v1, b_v2, coll1, coll2;

    always #5 clk = ~clk;

    dualmem_widen_param #(.NARROW_W(16), .RATIO(4), .WIDE_DEPTH(512), .READ_LAT(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_en_i(a_en), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wd),
        .a_rdata_o(a_rd1), .a_rvalid_o(a_v1),
        .b_en_i(b_en), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wd),
        .b_rdata_o(b_rd1), .b_rvalid_o(b_v1),
        .coll_o(coll1), .coll_clr_i(clr)
    );

    dualmem_widen_param #(.NARROW_W(16), .RATIO(4), .WIDE_DEPTH(512), .READ_LAT(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_en_i(a_en), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wd),
        .a_rdata_o(a_rd2), .a_rvalid_o(a_v2),
        .b_en_i(b_en), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wd),
        .b_rdata_o(b_rd2), .b_rvalid_o(b_v2),
        .coll_o(coll2), .coll_clr_i(clr)
    );

    // ---------------- reference model: flat little-endian byte memory ----------------
    typedef struct {
        int          due;
        int          id;     // 0:A lat1 1:B lat1 2:A lat2 3:B lat2
        logic [63:0] data;
    } pend_t;

    logic [7:0]  mem_m [D*WB];
    pend_t       pq[$];
    logic [63:0] last_d [4];
    bit          coll_m;
    int          cyc;
    int          errors;
    int          checks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit a_wr_byte(input int idx);
        return a_en && (a_be != 2'b00) && (idx / NB == int'(a_addr)) && a_be[idx % NB];
    endfunction

    function automatic bit b_wr_byte(input int idx);
        return b_en && (b_be != 8'h00) && (idx / WB == int'(b_addr)) && b_be[idx % WB];
    endfunction

    function automatic logic [7:0] rd_byte(input int idx, input bit reader_is_a);
        logic [7:0] v;
        v = mem_m[idx];
        if (FWD && reader_is_a && b_wr_byte(idx))  v = b_wd[(idx % WB)*8 +: 8];
        if (FWD && !reader_is_a && a_wr_byte(idx)) v = a_wd[(idx % NB)*8 +: 8];
        return v;
    endfunction

    task automatic check_outputs();
        bit          ev [4];
        logic [63:0] act_d [4];
        logic        act_v [4];
        for (int i = 0; i < 4; i++) ev[i] = 1'b0;
        foreach (pq[i]) begin
            if (pq[i].due == cyc) begin
                ev[pq[i].id]     = 1'b1;
                last_d[pq[i].id] = pq[i].data;
            end
        end
        while (pq.size() > 0 && pq[0].due <= cyc) void'(pq.pop_front());
        act_v[0] = a_v1; act_d[0] = {48'h0, a_rd1};
        act_v[1] = b_v1; act_d[1] = b_rd1;
        act_v[2] = a_v2; act_d[2] = {48'h0, a_rd2};
        act_v[3] = b_v2; act_d[3] = b_rd2;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_rvalid[%0d]", i), {63'h0, act_v[i]}, {63'h0, ev[i]});
            chk($sformatf("model_rdata[%0d]", i), act_d[i], last_d[i]);
        end
        chk("model_coll1", {63'h0, coll1}, {63'h0, coll_m});
        chk("model_coll2", {63'h0, coll2}, {63'h0, coll_m});
    endtask

    // One clock of traffic: predict reads from the pre-edge memory, then commit writes.
    task automatic step(input bit quiet);
        logic [63:0] ra, rb;
        bit          ov;
        ra = '0; rb = '0; ov = 1'b0;
        if (a_en && a_be == 2'b00)
            for (int j = 0; j < NB; j++) ra[j*8 +: 8] = rd_byte(int'(a_addr)*NB + j, 1'b1);
        if (b_en && b_be == 8'h00)
            for (int j = 0; j < WB; j++) rb[j*8 +: 8] = rd_byte(int'(b_addr)*WB + j, 1'b0);
        for (int j = 0; j < NB; j++)
            if (a_wr_byte(int'(a_addr)*NB + j) && b_wr_byte(int'(a_addr)*NB + j)) ov = 1'b1;
        if (a_en && a_be == 2'b00) begin
            pq.push_back('{due: cyc + 1, id: 0, data: ra});
            pq.push_back('{due: cyc + 2, id: 2, data: ra});
        end
        if (b_en && b_be == 8'h00) begin
            pq.push_back('{due: cyc + 1, id: 1, data: rb});
            pq.push_back('{due: cyc + 2, id: 3, data: rb});
        end
        if (!quiet)
            $display("cyc=%0d A en=%0d be=%h addr=%0d wd=%h | B en=%0d be=%h addr=%0d wd=%h | clr=%0d",
                     cyc, a_en, a_be, a_addr, a_wd, b_en, b_be, b_addr, b_wd, clr);
        @(posedge clk);
        cyc++;
        for (int j = 0; j < NB; j++)
            if (a_wr_byte(int'(a_addr)*NB + j)) mem_m[int'(a_addr)*NB + j] = a_wd[j*8 +: 8];
        for (int j = 0; j < WB; j++)
            if (b_wr_byte(int'(b_addr)*WB + j)) mem_m[int'(b_addr)*WB + j] = b_wd[j*8 +: 8];
        if (ov) coll_m = 1'b1;
        else if (clr) coll_m = 1'b0;
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        a_en = 1'b0; a_be = '0; a_addr = '0; a_wd = '0;
        b_en = 1'b0; b_be = '0; b_addr = '0; b_wd = '0;
        clr  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk({tag, "_a_rvalid1"}, {63'h0, a_v1}, 64'h0);
        chk({tag, "_b_rvalid1"}, {63'h0, b_v1}, 64'h0);
        chk({tag, "_a_rvalid2"}, {63'h0, a_v2}, 64'h0);
        chk({tag, "_b_rvalid2"}, {63'h0, b_v2}, 64'h0);
        chk({tag, "_a_rdata2"}, {48'h0, a_rd2}, 64'h0);
        chk({tag, "_b_rdata2"}, b_rd2, 64'h0);
        chk({tag, "_a_rdata1"}, {48'h0, a_rd1}, 64'h0);
        chk({tag, "_coll"}, {62'h0, coll1, coll2}, 64'h0);
        pq.delete();
        for (int i = 0; i < 4; i++) last_d[i] = '0;
        coll_m = 1'b0;
        $display("cyc=%0d reset asserted (%s)", cyc, tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table (expectations for the LAT=1 instance) ----------------
    typedef struct {
        bit          a_en;
        logic [1:0]  a_be;
        logic [10:0] a_addr;
        logic [15:0] a_wd;
        bit          b_en;
        logic [7:0]  b_be;
        logic [8:0]  b_addr;
        logic [63:0] b_wd;
        bit          clr;
        bit          ea_v;
        logic [15:0] ea_d;
        bit          eb_v;
        logic [63:0] eb_d;
        bit          e_coll;
    } vec_t;

    localparam logic [15:0] RD_OVER_WR = FWD ? 16'h9999 : 16'h5678;
    localparam logic [63:0] W1         = 64'h0000_0000_BEEF_0000;
    localparam logic [63:0] W1B        = 64'h0000_0000_BEEF_CDAB;
    localparam logic [63:0] Z64        = 64'h0;

    vec_t tbl [23];

    initial begin
        errors = 0; checks = 0; cyc = 0; coll_m = 1'b0;
        for (int i = 0; i < 4; i++) last_d[i] = '0;

        //          a_en a_be   a_addr     a_wd     b_en b_be   b_addr   b_wd                     clr   ea_v ea_d     eb_v eb_d   coll
        tbl[0]  = '{1'b1, 2'b11, 11'd5,  16'hBEEF, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b0, 16'h0000, 1'b0, Z64, 1'b0};
        tbl[1]  = '{1'b0, 2'b00, 11'd0,  16'h0000, 1'b1, 8'h00, 9'd1, Z64,                    1'b0, 1'b0, 16'h0000, 1'b1, W1,  1'b0};
        tbl[2]  = '{1'b0, 2'b00, 11'd0,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b0, 16'h0000, 1'b0, W1,  1'b0};
        tbl[3]  = '{1'b0, 2'b00, 11'd0,  16'h0000, 1'b1, 8'hFF, 9'd2, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 16'h0000, 1'b0, W1,  1'b0};
        tbl[4]  = '{1'b1, 2'b00, 11'd8,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b1, 16'h4444, 1'b0, W1,  1'b0};
        tbl[5]  = '{1'b1, 2'b00, 11'd9,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b1, 16'h3333, 1'b0, W1,  1'b0};
        tbl[6]  = '{1'b1, 2'b00, 11'd10, 16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b1, 16'h2222, 1'b0, W1,  1'b0};
        tbl[7]  = '{1'b1, 2'b00, 11'd11, 16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b1, 16'h1111, 1'b0, W1,  1'b0};
        tbl[8]  = '{1'b0, 2'b00, 11'd0,  16'h0000, 1'b1, 8'hFF, 9'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 16'h1111, 1'b0, W1,  1'b0};
        tbl[9]  = '{1'b0, 2'b00, 11'd0,  16'h0000, 1'b1, 8'h03, 9'd2, 64'h0000_0000_0000_AA55, 1'b0, 1'b0, 16'h1111, 1'b0, W1,  1'b0};
        tbl[10] = '{1'b1, 2'b00, 11'd8,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b1, 16'hAA55, 1'b0, W1,  1'b0};
        tbl[11] = '{1'b1, 2'b00, 11'd9,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b1, 16'hFFFF, 1'b0, W1,  1'b0};
        tbl[12] = '{1'b1, 2'b11, 11'd0,  16'h1234, 1'b1, 8'h03, 9'd0, 64'h0000_0000_0000_5678, 1'b0, 1'b0, 16'hFFFF, 1'b0, W1,  1'b1};
        tbl[13] = '{1'b1, 2'b00, 11'd0,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b1, 16'h5678, 1'b0, W1,  1'b1};
        tbl[14] = '{1'b0, 2'b00, 11'd0,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b1, 1'b0, 16'h5678, 1'b0, W1,  1'b0};
        tbl[15] = '{1'b1, 2'b00, 11'd0,  16'h0000, 1'b1, 8'h03, 9'd0, 64'h0000_0000_0000_9999, 1'b0, 1'b1, RD_OVER_WR, 1'b0, W1, 1'b0};
        tbl[16] = '{1'b1, 2'b00, 11'd0,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b1, 16'h9999, 1'b0, W1,  1'b0};
        tbl[17] = '{1'b1, 2'b11, 11'd1,  16'h0001, 1'b1, 8'h0C, 9'd0, 64'h0000_0000_7777_0000, 1'b1, 1'b0, 16'h9999, 1'b0, W1,  1'b1};
        tbl[18] = '{1'b1, 2'b00, 11'd1,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b1, 1'b1, 16'h7777, 1'b0, W1,  1'b0};
        tbl[19] = '{1'b1, 2'b01, 11'd4,  16'h00AB, 1'b1, 8'h02, 9'd1, 64'h0000_0000_0000_CD00, 1'b0, 1'b0, 16'h7777, 1'b0, W1,  1'b0};
        tbl[20] = '{1'b0, 2'b00, 11'd0,  16'h0000, 1'b1, 8'h00, 9'd1, Z64,                    1'b0, 1'b0, 16'h7777, 1'b1, W1B, 1'b0};
        tbl[21] = '{1'b1, 2'b00, 11'd5,  16'h0000, 1'b1, 8'h00, 9'd1, Z64,                    1'b0, 1'b1, 16'hBEEF, 1'b1, W1B, 1'b0};
        tbl[22] = '{1'b0, 2'b00, 11'd0,  16'h0000, 1'b0, 8'h00, 9'd0, Z64,                    1'b0, 1'b0, 16'hBEEF, 1'b0, W1B, 1'b0};

        idle_inputs();
        do_reset("reset");

        // Zero the whole memory through port B so every later read is defined.
        for (int w = 0; w < D; w++) begin
            b_en = 1'b1; b_be = 8'hFF; b_addr = 9'(w); b_wd = '0;
            step(1'b1);
        end
        idle_inputs();

        for (int i = 0; i < 23; i++) begin
            a_en = tbl[i].a_en; a_be = tbl[i].a_be; a_addr = tbl[i].a_addr; a_wd = tbl[i].a_wd;
            b_en = tbl[i].b_en; b_be = tbl[i].b_be; b_addr = tbl[i].b_addr; b_wd = tbl[i].b_wd;
            clr  = tbl[i].clr;
            step(1'b0);
            chk($sformatf("vec%0d_a_rvalid", i), {63'h0, a_v1}, {63'h0, tbl[i].ea_v});
            chk($sformatf("vec%0d_a_rdata", i), {48'h0, a_rd1}, {48'h0, tbl[i].ea_d});
            chk($sformatf("vec%0d_b_rvalid", i), {63'h0, b_v1}, {63'h0, tbl[i].eb_v});
            chk($sformatf("vec%0d_b_rdata", i), b_rd1, tbl[i].eb_d);
            chk($sformatf("vec%0d_coll", i), {63'h0, coll1}, {63'h0, tbl[i].e_coll});
        end
        idle_inputs();

        // Random traffic confined to 8 wide words so collisions and overlaps are frequent.
        for (int n = 0; n < 400; n++) begin
            a_en   = ($urandom_range(0, 3) != 0);
            a_be   = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
            a_addr = 11'($urandom_range(0, 31));
            a_wd   = 16'($urandom);
            b_en   = ($urandom_range(0, 3) != 0);
            b_be   = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 255));
            b_addr = 9'($urandom_range(0, 7));
            b_wd   = {$urandom, $urandom};
            clr    = ($urandom_range(0, 7) == 0);
            step(1'b0);
        end
        idle_inputs();
        step(1'b0);
        step(1'b0);

        // Reset with reads still inside the two-stage pipeline.
        a_en = 1'b1; a_addr = 11'd8; b_en = 1'b1; b_addr = 9'd2;
        step(1'b0);
        a_addr = 11'd9; b_addr = 9'd3;
        step(1'b0);
        do_reset("midflight");
        for (int n = 0; n < 4; n++) step(1'b0);
        chk("post_reset_a_rvalid2", {63'h0, a_v2}, 64'h0);
        chk("post_reset_b_rdata2", b_rd2, 64'h0);

        // Memory survives reset: re-read the same locations through both instances.
        a_en = 1'b1; a_addr = 11'd8; b_en = 1'b1; b_addr = 9'd2;
        step(1'b0);
        idle_inputs();
        step(1'b0);
        chk("reread_a_lat2", {48'h0, a_rd2}, {48'h0, mem_m[8*NB+1], mem_m[8*NB]});
        chk("reread_a_valid_lat2", {63'h0, a_v2}, 64'h1);
        step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dualmem_widen_param.md
Name: dualmem_widen_param

Overview:
- Single-clock true dual-port RAM with asymmetric widths: narrow port A, wide port B.
- Port B width = RATIO × port A width.
- Generalised successor of the fixed 16/64-bit Ethernet buffer RAM: parametrised width, ratio and depth, byte-enable writes on both ports, configurable read latency with valid tracking, and collision detection.
- Sits between the Ethernet MAC byte/halfword datapath (port A) and the AXI/host wide datapath (port B).

Parameters:
- NARROW_W, 16, port A data width in bits; multiple of 8.
- RATIO, 4, wide-to-narrow width ratio; power of 2, range 1..8.
- WIDE_DEPTH, 512, number of wide words; power of 2.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).

Ports:
- clk_i, in, 1, single clock for both ports.
- rst_ni, in, 1, asynchronous active-low reset.
- a_en_i, in, 1, port A access request.
- a_be_i, in, NARROW_W/8, port A byte write enables; all zero = read.
- a_addr_i, in, $clog2(WIDE_DEPTH*RATIO), port A narrow-word address.
- a_wdata_i, in, NARROW_W, port A write data.
- a_rdata_o, out, NARROW_W, port A read data.
- a_rvalid_o, out, 1, a_rdata_o valid.
- b_en_i, in, 1, port B access request.
- b_be_i, in, NARROW_W*RATIO/8, port B byte write enables.
- b_addr_i, in, $clog2(WIDE_DEPTH), port B wide-word address.
- b_wdata_i, in, NARROW_W*RATIO, port B write data.
- b_rdata_o, out, NARROW_W*RATIO, port B read data.
- b_rvalid_o, out, 1, b_rdata_o valid.
- coll_o, out, 1, sticky: a same-cycle write/write byte collision has occurred.
- coll_clr_i, in, 1, clears coll_o.

Behaviour:
- Mapping is little-endian. Narrow address N maps to wide word N/RATIO, lane k = N mod RATIO, bits [k*NARROW_W +: NARROW_W].
- Storage is RATIO lane RAMs, each WIDE_DEPTH × NARROW_W.
  - Port A enables only lane k; its byte enables are shifted into that lane.
  - Port B enables all lanes with its own byte enables.
- Write: takes effect at the clock edge when en=1 and be≠0. Only bytes whose be bit is 1 change.
- Read: en=1 with be=0. Data appears READ_LAT cycles later with rvalid=1 for exactly one cycle per request. Back-to-back requests give one valid per cycle.
  - Port A read returns lane k selected by a registered copy of k, delayed READ_LAT.
- Write cycles do not raise rvalid. Writes are not acknowledged and always complete.
- Same-port read-during-write cannot occur (one address per port per cycle).
- Cross-port, same cycle, same byte:
  - A reads while B writes (or vice versa): reader gets OLD data (read-first).
  - Both write: port B's value wins. coll_o sets on the following cycle.
  - Writes to disjoint bytes of the same word both take effect.
- coll_o:
  - Set takes priority over coll_clr_i in the same cycle.
  - Reset value 0.
- Reset (async assert, sync deassert handled upstream):
  - a_rvalid_o, b_rvalid_o, coll_o = 0.
  - a_rdata_o, b_rdata_o = 0.
  - All pipeline and lane-select registers cleared.
  - Memory contents are not reset.
  - Reads in flight when reset asserts are dropped; no rvalid is issued after reset.
- rdata holds its last value while rvalid=0.
- Address wrap: none; addresses are full-range by construction.

Optional Feature:
- Macro: DUALMEM_WRITE_FORWARD_EN.
- Defined: in a cross-port same-cycle read/write to the same byte, the reader gets the NEW written byte (write-first bypass through the read pipeline). Unwritten bytes return stored data.
- Undefined: read-first, as above.

Decomposition:
- Package dualmem_pkg:
  - Address and lane-index width helper functions.
  - Lane-enable expansion function (narrow be → wide be for lane k).
  - READ_LAT legality check constant.
- Sub-module dualmem_lane: one WIDE_DEPTH × NARROW_W single-clock true dual-port byte-enable RAM with read-first semantics.
  - Instantiated RATIO times.
  - This is the only file swapped for FPGA primitives or technology macros.

Test Plan:
- Write A addr 5 = 0xBEEF; read B addr 1 (READ_LAT=1) → b_rdata_o[31:16]=0xBEEF, b_rvalid_o high exactly 1 cycle after the request.
- Write B addr 2 = 0x1111_2222_3333_4444, be=0xFF; read A addr 8..11 back-to-back → 0x4444, 0x3333, 0x2222, 0x1111 on consecutive cycles, rvalid continuous.
- Partial write B be=0x03 data 0xAA55 over pre-filled 0xFFFF… → only bytes 0–1 change; read A addr 8 = 0xAA55, addr 9 unchanged.
- Same cycle: A writes addr 0 = 0x1234, B writes addr 0 lane 0 = 0x5678 → readback 0x5678; coll_o=1 next cycle; coll_clr_i pulse → 0.
- Same cycle: A reads addr 0 while B writes 0x9999 to it → 0 / old value without the macro, 0x9999 with DUALMEM_WRITE_FORWARD_EN.
- READ_LAT=2: issue reads, assert rst_ni low mid-flight → rvalid outputs 0 immediately and none appear after release; memory content is preserved on re-read.
